// File: rtl/jtcop_sec_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_sec_bridge_if
// Description : Bus bundle between the main-CPU security strobes, the MCU
//               register window and jtcop_sec_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtcop_sec_bridge_if;
  // Main CPU side
  logic        main_wr;
  logic        main_rd;
  logic [15:0] main_din;
  logic [15:0] main_dout;
  logic        sec2;
  // MCU side
  logic [1:0]  mcu_addr;
  logic        mcu_we;
  logic        mcu_re;
  logic [7:0]  mcu_wdata;
  logic [7:0]  mcu_rdata;
  logic        mcu_int_n;
  logic        overrun;

  // Driver of the bridge (main decoder + MCU core, or a testbench)
  modport master (
    output main_wr, main_rd, main_din,
    output mcu_addr, mcu_we, mcu_re, mcu_wdata,
    input  main_dout, sec2, mcu_rdata, mcu_int_n, overrun
  );

  // The bridge itself
  modport slave (
    input  main_wr, main_rd, main_din,
    input  mcu_addr, mcu_we, mcu_re, mcu_wdata,
    output main_dout, sec2, mcu_rdata, mcu_int_n, overrun
  );
endinterface
`default_nettype wire

// File: rtl/jtcop_sec_bridge.sv
`default_nettype none
// ============================================================================
// Module      : jtcop_sec_bridge
// Description : MCU-side end of the main-CPU security mailbox. Captures main
//               CPU commands for the MCU, and presents MCU responses back to
//               the main CPU on main_dout with the sec2 ready line.
//               Optional macro JTCOP_SEC_TIMEOUT_EN: abandons a response the
//               main CPU has not read within TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module jtcop_sec_bridge #(
  parameter int          GAP_W   = 2,
  parameter logic [23:0] TIMEOUT = 24'd4_000_000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  jtcop_sec_bridge_if.slave  bus
);

  // Gap counter holds GAP_W-1 down to 0, so it needs clog2(GAP_W) bits
  localparam int c_GAP_CW = (GAP_W > 2) ? $clog2(GAP_W) : 1;
  localparam logic [c_GAP_CW-1:0] c_GAP_LOAD = c_GAP_CW'(GAP_W - 1);
  localparam logic [1:0] c_A_LO   = 2'd0;
  localparam logic [1:0] c_A_HI   = 2'd1;
  localparam logic [1:0] c_A_STAT = 2'd2;
  localparam logic [1:0] c_A_ACK  = 2'd3;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_PEND = 2'd1,
    R_GAP  = 2'd2
  } resp_state_t;

  // Strobe edge detection
  logic r_wr_d;
  logic r_rd_d;
  logic w_wr_edge;
  logic w_rd_edge;

  // Command / staging registers
  logic [15:0] r_cmd;
  logic [15:0] r_stage;
  logic        r_cmd_pending;
  logic        w_cmd_pending_nxt;
  logic        r_overrun;
  logic        r_int_n;
  logic [7:0]  r_rdata;

  // MCU strobe decode
  logic w_we;
  logic w_re;
  logic w_commit;
  logic w_ack;

  // Response FSM
  resp_state_t         r_state;
  resp_state_t         w_state_nxt;
  logic [15:0]         r_dout;
  logic [15:0]         w_dout_nxt;
  logic                r_sec2;
  logic                w_sec2_nxt;
  logic [c_GAP_CW-1:0] r_gap_cnt;
  logic [c_GAP_CW-1:0] w_gap_cnt_nxt;
  logic                w_resp_ovr;
  logic                w_resp_pending;
  logic                w_to_hit;

  assign w_wr_edge = bus.main_wr & ~r_wr_d;
  assign w_rd_edge = bus.main_rd & ~r_rd_d;

  // A simultaneous write and read is treated as a write only
  assign w_we     = bus.mcu_we;
  assign w_re     = bus.mcu_re & ~bus.mcu_we;
  assign w_commit = w_we & (bus.mcu_addr == c_A_STAT);
  assign w_ack    = w_we & (bus.mcu_addr == c_A_ACK);

  assign w_resp_pending = (r_state != R_IDLE);

  // A new command edge beats an ack landing in the same cycle
  assign w_cmd_pending_nxt = w_wr_edge ? 1'b1 : (w_ack ? 1'b0 : r_cmd_pending);

  // Delayed copies of the main strobes for 0->1 detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_d <= 1'b0;
      r_rd_d <= 1'b0;
    end else begin
      r_wr_d <= bus.main_wr;
      r_rd_d <= bus.main_rd;
    end
  end

  // Command capture, pending/overrun flags and MCU interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd         <= 16'h0000;
      r_cmd_pending <= 1'b0;
      r_overrun     <= 1'b0;
      r_int_n       <= 1'b1;
    end else begin
      if (w_wr_edge) begin
        r_cmd <= bus.main_din;
      end
      r_cmd_pending <= w_cmd_pending_nxt;
      // Interrupt follows the next pending value so it drops with the capture
      r_int_n       <= ~w_cmd_pending_nxt;
      // New error events take precedence over a clear in the same cycle
      if ((w_wr_edge & r_cmd_pending) | w_resp_ovr) begin
        r_overrun <= 1'b1;
      end else if (w_ack & bus.mcu_wdata[0]) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // MCU staging writes and registered read-back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= 16'h0000;
      r_rdata <= 8'hff;
    end else begin
      if (w_we && bus.mcu_addr == c_A_LO) begin
        r_stage[7:0] <= bus.mcu_wdata;
      end
      if (w_we && bus.mcu_addr == c_A_HI) begin
        r_stage[15:8] <= bus.mcu_wdata;
      end
      if (w_re) begin
        case (bus.mcu_addr)
          c_A_LO:   r_rdata <= r_cmd[7:0];
          c_A_HI:   r_rdata <= r_cmd[15:8];
          c_A_STAT: r_rdata <= {5'b0, r_overrun, w_resp_pending, r_cmd_pending};
          default:  r_rdata <= 8'hff;
        endcase
      end
    end
  end

`ifdef JTCOP_SEC_TIMEOUT_EN
  logic [23:0] r_to_cnt;

  assign w_to_hit = (r_state == R_PEND) && (r_to_cnt == TIMEOUT - 24'd1);

  // Read-timeout counter: counts only while staying in R_PEND
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= 24'd0;
    end else if (r_state == R_PEND && w_state_nxt == R_PEND) begin
      r_to_cnt <= r_to_cnt + 24'd1;
    end else begin
      r_to_cnt <= 24'd0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_to_hit         = 1'b0;
`endif

  // Response FSM state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_dout    <= 16'h0000;
      r_sec2    <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dout    <= w_dout_nxt;
      r_sec2    <= w_sec2_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // Response FSM next-state logic; a commit always outranks a main read
  always_comb begin
    w_state_nxt   = r_state;
    w_dout_nxt    = r_dout;
    w_sec2_nxt    = r_sec2;
    w_gap_cnt_nxt = r_gap_cnt;
    w_resp_ovr    = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (w_commit) begin
          w_dout_nxt  = r_stage;
          w_sec2_nxt  = 1'b1;
          w_state_nxt = R_PEND;
        end
      end
      R_PEND: begin
        if (w_commit) begin
          // Unread response replaced: drop sec2 so a fresh edge follows
          w_dout_nxt    = r_stage;
          w_sec2_nxt    = 1'b0;
          w_resp_ovr    = 1'b1;
          w_gap_cnt_nxt = c_GAP_LOAD;
          w_state_nxt   = R_GAP;
        end else if (w_rd_edge) begin
          w_sec2_nxt  = 1'b0;
          w_state_nxt = R_IDLE;
        end else if (w_to_hit) begin
          w_sec2_nxt  = 1'b0;
          w_resp_ovr  = 1'b1;
          w_state_nxt = R_IDLE;
        end
      end
      R_GAP: begin
        if (w_commit) begin
          w_dout_nxt    = r_stage;
          w_gap_cnt_nxt = c_GAP_LOAD;
        end else if (r_gap_cnt == '0) begin
          w_sec2_nxt  = 1'b1;
          w_state_nxt = R_PEND;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - c_GAP_CW'(1);
        end
      end
      default: begin
        w_sec2_nxt  = 1'b0;
        w_state_nxt = R_IDLE;
      end
    endcase
  end

  assign bus.main_dout = r_dout;
  assign bus.sec2      = r_sec2;
  assign bus.mcu_rdata = r_rdata;
  assign bus.mcu_int_n = r_int_n;
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire
